// File: rtl/gas_pattern_detector.sv
// gas_pattern_detector: detects NUM_PAT programmable bit patterns on a serial stream with counters and sticky alarms
module gas_pattern_detector #(
  parameter int NUM_PAT = 3,
  parameter int PAT_LEN = 8,
  parameter int CNT_W   = 4,
  parameter int THRESH  = 2,
  localparam int IW = NUM_PAT > 1 ? $clog2(NUM_PAT) : 1,
  localparam int LW = $clog2(PAT_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     din,
  input  logic                     din_valid,
  input  logic                     cfg_we,
  input  logic [IW-1:0]            cfg_idx,
  input  logic [PAT_LEN-1:0]       cfg_pattern,
  input  logic [LW-1:0]            cfg_len,
  input  logic [NUM_PAT-1:0]       alarm_clr,
  output logic [NUM_PAT-1:0]       match,
  output logic [NUM_PAT-1:0]       alarm,
  output logic [NUM_PAT*CNT_W-1:0] match_cnt
);
  localparam logic [LW-1:0] PL = LW'(PAT_LEN);
  localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);
  logic [PAT_LEN-1:0] hist, cand;
  logic [LW-1:0] fill;
  logic [PAT_LEN-1:0] pat [NUM_PAT];
  logic [PAT_LEN-1:0] mask [NUM_PAT];
  logic [LW-1:0] len [NUM_PAT];
  logic [CNT_W-1:0] cnt [NUM_PAT];
  logic [CNT_W-1:0] nxt [NUM_PAT];
  logic [NUM_PAT-1:0] hit, wr;
  assign cand = {hist[PAT_LEN-2:0], din};
  // fill+1 >= len guards against matching on the zeros left by reset
  always_comb begin
    for (int i = 0; i < NUM_PAT; i++) begin
      for (int b = 0; b < PAT_LEN; b++) mask[i][b] = LW'(b) < len[i];
      wr[i]  = cfg_we && cfg_idx == IW'(i);
      nxt[i] = &cnt[i] ? cnt[i] : cnt[i] + 1'b1;
      hit[i] = din_valid && len[i] != '0 && len[i] <= PL &&
               ({1'b0, fill} + 1'b1) >= {1'b0, len[i]} &&
               ((cand ^ pat[i]) & mask[i]) == '0 && !wr[i];
    end
  end
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      hist  <= '0;
      fill  <= '0;
      match <= '0;
      alarm <= '0;
      for (int i = 0; i < NUM_PAT; i++) begin
        pat[i] <= '0;
        len[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      if (din_valid) begin
        hist <= cand;
        fill <= fill == PL ? fill : fill + 1'b1;
      end
      match <= hit;
      for (int i = 0; i < NUM_PAT; i++) begin
        if (wr[i]) begin
          pat[i] <= cfg_pattern;
          len[i] <= cfg_len;
        end
        if (wr[i] || alarm_clr[i]) begin
          cnt[i]   <= '0;
          alarm[i] <= 1'b0;
        end else if (hit[i]) begin
          cnt[i] <= nxt[i];
          if (nxt[i] >= TH) alarm[i] <= 1'b1;
        end
      end
    end
  end
  for (genvar g = 0; g < NUM_PAT; g++) begin : g_cnt
    assign match_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end
endmodule
